ai_throw_sequencer: RTL and testbench
=====================================

// Module: ai_throw_sequencer
// PURPOSE
//  Parametrised successor of the AI bowler. It runs an LFSR-driven throw generator behind a
//  req/throw/ack handshake, with a difficulty mode, programmable throw tables, a per-over ball
//  counter and an inter-ball cooldown. It sits between the game controller (en/gameOver/req)
//  and the ball-motion logic, which consumes dy/dx.
// PARAMETERS
//  LFSR_W     19                      LFSR width in bits (>= 4)
//  TAPS       19'h40023               feedback tap mask; bit k set => rand[k] is XORed into fb
//  SEED       19'h7FFFF               LFSR value after reset; must be nonzero
//  DW         4                       width of dy/dx
//  DY_TABLE   64'h2122_2212_2221_2221 16 packed dy entries; entry i at [i*DW +: DW]
//  DX_TABLE   64'h4232_4323_4322_3342 16 packed dx entries; same packing as DY_TABLE
//  BALLS      6                       balls per over (>= 1)
//  COOLDOWN   3                       idle cycles after each ack (0 allowed)
// PORTS
//  clock      in   1      system clock; all state updates on its rising edge
//  reset      in   1      synchronous, active-high reset
//  en         in   1      AI bowling turn active
//  gameOver   in   1      game finished; aborts any throw in progress
//  req        in   1      request the next ball (level; sampled in IDLE only)
//  mode       in   2      difficulty; added to the table dx with saturation
//  ack        in   1      ball-motion logic has consumed dy/dx
//  throw      out  1      dy/dx valid; throw is held until ack or abort
//  dy         out  DW     vertical step of the current throw
//  dx         out  DW     horizontal step of the current throw
//  ball_cnt   out  3      balls completed in the current over, range 0..BALLS-1
//  over_done  out  1      one-cycle pulse when the BALLS-th ball is acked
//  busy       out  1      high whenever the state is not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rand=SEED, throw=0, dy=0, dx=0, ball_cnt=0, over_done=0, busy=0,
//    cooldown counter=0. Reset overrides all other inputs in the same cycle.
//  LFSR: fb = ^(rand & TAPS). On a DRAW cycle only, rand <= {rand[LFSR_W-2:0], fb}.
//    The LFSR does not free-run, so the throw sequence is deterministic per SEED.
//  Table index: idx = rand[3:0], taken before the step in the same DRAW cycle.
//  Table lookup:
//    - dy <= DY_TABLE[idx].
//    - dx <= min(DX_TABLE[idx] + mode, 2^DW-1); the sum is formed at DW+2 bits, then saturated.
//  FSM:
//    - IDLE: if en && !gameOver && req -> DRAW.
//    - DRAW (exactly 1 cycle): latch dy/dx, step the LFSR -> PRESENT.
//    - PRESENT: throw=1, dy/dx held stable.
//        On ack, throw drops at the next edge.
//        If ball_cnt==BALLS-1 then ball_cnt<=0 and over_done pulses; else ball_cnt++.
//        Next state is COOL(COOLDOWN) if COOLDOWN>0, else IDLE.
//    - COOL: count down to 0, then -> IDLE. req is ignored during COOL.
//  Latency: req sampled high in IDLE at edge t => throw=1 after edge t+2.
//    The earliest next req is accepted COOLDOWN+1 cycles after the ack edge.
//  Abort: gameOver=1 or en=0 in DRAW, PRESENT or COOL => IDLE at the next edge.
//    - throw drops to 0.
//    - dy/dx keep their last values.
//    - An un-acked ball is not counted.
//    - An LFSR step already taken in DRAW stands.
//  Simultaneous ack and gameOver in PRESENT: the ball counts (ball_cnt/over_done update),
//    then the FSM goes to IDLE.
//  ack outside PRESENT is ignored. over_done is only ever high for 1 cycle.
// TESTING
//  T1: reset, en=1, mode=0, req=1 -> throw=1 on the 3rd edge after req; dy=2, dx=4 (idx 15).
//  T2: ack T1, wait COOLDOWN, req again -> idx 14: dy=1, dx=2; ball_cnt=2 after its ack.
//  T3: mode=3 on the first throw after reset -> dx=7, dy=2; sweep mode 0..3 -> dx=4,5,6,7.
//  T4: 6 req/ack balls -> ball_cnt 1..5, then 0 with over_done high for exactly 1 cycle.
//  T5: gameOver mid-PRESENT -> throw=0 next cycle, ball_cnt unchanged, state IDLE;
//      ack+gameOver in the same cycle -> ball counted.
//  T6: reset asserted in PRESENT, in COOL and on the over_done cycle -> all outputs return to
//      reset values at the next edge; the next throw again gives dy=2, dx=4.

Source files
------------

// File: rtl/ai_throw_sequencer.sv
// AI bowler throw sequencer: LFSR-driven dy/dx generator behind a
// req/throw/ack handshake with difficulty, ball counting and cooldown.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   en, gameOver   turn active / game finished (either aborts a throw)
//   req            request next ball, sampled in IDLE only
//   mode[1:0]      difficulty, added to the table dx with saturation
//   ack            ball-motion logic consumed dy/dx
//   throw          dy/dx valid, held until ack or abort
//   dy, dx         current throw steps
//   ball_cnt[2:0]  balls completed in the current over
//   over_done      one-cycle pulse on the last ball of an over
//   busy           state is not IDLE
module ai_throw_sequencer #(
    parameter int                  LFSR_W   = 19,
    parameter logic [LFSR_W-1:0]   TAPS     = 19'h40023,
    parameter logic [LFSR_W-1:0]   SEED     = 19'h7FFFF,
    parameter int                  DW       = 4,
    parameter logic [16*DW-1:0]    DY_TABLE = 64'h2122_2212_2221_2221,
    parameter logic [16*DW-1:0]    DX_TABLE = 64'h4232_4323_4322_3342,
    parameter int                  BALLS    = 6,
    parameter int                  COOLDOWN = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          gameOver,
    input  logic          req,
    input  logic [1:0]    mode,
    input  logic          ack,
    output logic          throw,
    output logic [DW-1:0] dy,
    output logic [DW-1:0] dx,
    output logic [2:0]    ball_cnt,
    output logic          over_done,
    output logic          busy
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [DW+1:0] DX_MAX = (DW+2)'((1 << DW) - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        PRESENT,
        COOL
    } state_t;

    state_t            state_q, state_n;
    logic [LFSR_W-1:0] lfsr_q, lfsr_n;
    logic [DW-1:0]     dy_q, dy_n;
    logic [DW-1:0]     dx_q, dx_n;
    logic              throw_q, throw_n;
    logic [2:0]        cnt_q, cnt_n;
    logic              od_q, od_n;
    logic [CW-1:0]     cool_q, cool_n;

    logic              abort;
    logic              fb;
    logic [3:0]        idx;
    logic [DW+1:0]     dx_sum;
    logic [DW-1:0]     dx_sat;
    logic              counted;

    always_comb begin
        abort   = gameOver || !en;
        fb      = ^(lfsr_q & TAPS);
        idx     = lfsr_q[3:0];
        dx_sum  = (DW+2)'(DX_TABLE[int'(idx)*DW +: DW]) + (DW+2)'(mode);
        dx_sat  = (dx_sum > DX_MAX) ? {DW{1'b1}} : dx_sum[DW-1:0];
        // A ball is consumed only once it has actually been shown.
        counted = (state_q == PRESENT) && throw_q && ack;
    end

    always_comb begin
        state_n = state_q;
        lfsr_n  = lfsr_q;
        dy_n    = dy_q;
        dx_n    = dx_q;
        throw_n = 1'b0;
        cnt_n   = cnt_q;
        od_n    = 1'b0;
        cool_n  = cool_q;

        unique case (state_q)
            IDLE: begin
                if (en && !gameOver && req) begin
                    state_n = DRAW;
                end
            end
            DRAW: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    dy_n    = DY_TABLE[int'(idx)*DW +: DW];
                    dx_n    = dx_sat;
                    lfsr_n  = {lfsr_q[LFSR_W-2:0], fb};
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (counted) begin
                    if (cnt_q == 3'(BALLS - 1)) begin
                        cnt_n = 3'd0;
                        od_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_q + 3'd1;
                    end
                end
                if (abort) begin
                    state_n = IDLE;
                end else if (counted) begin
                    if (COOLDOWN > 0) begin
                        state_n = COOL;
                        cool_n  = CW'(COOLDOWN - 1);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    throw_n = 1'b1;
                end
            end
            COOL: begin
                if (abort) begin
                    state_n = IDLE;
                    cool_n  = '0;
                end else if (cool_q == '0) begin
                    state_n = IDLE;
                end else begin
                    cool_n = cool_q - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            dy_q    <= '0;
            dx_q    <= '0;
            throw_q <= 1'b0;
            cnt_q   <= 3'd0;
            od_q    <= 1'b0;
            cool_q  <= '0;
        end else begin
            state_q <= state_n;
            lfsr_q  <= lfsr_n;
            dy_q    <= dy_n;
            dx_q    <= dx_n;
            throw_q <= throw_n;
            cnt_q   <= cnt_n;
            od_q    <= od_n;
            cool_q  <= cool_n;
        end
    end

    assign throw     = throw_q;
    assign dy        = dy_q;
    assign dx        = dx_q;
    assign ball_cnt  = cnt_q;
    assign over_done = od_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ai_throw_sequencer.sv
// Scoreboard bench for ai_throw_sequencer: a reference model predicts
// each throw, a negedge monitor pops and compares on every presentation.
module tb_ai_throw_sequencer;

    localparam logic [63:0] DYT    = 64'h2122_2212_2221_2221;
    localparam logic [63:0] DXT    = 64'h4232_4323_4322_3342;
    localparam logic [18:0] SEED_M = 19'h7FFFF;
    localparam logic [18:0] TAPS_M = 19'h40023;
    localparam int          NBALLS = 6;
    localparam int          NCOOL  = 3;

    logic       clock;
    logic       reset;
    logic       en;
    logic       gameOver;
    logic       req;
    logic [1:0] mode;
    logic       ack;
    logic       throw;
    logic [3:0] dy;
    logic [3:0] dx;
    logic [2:0] ball_cnt;
    logic       over_done;
    logic       busy;

    ai_throw_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .gameOver (gameOver),
        .req      (req),
        .mode     (mode),
        .ack      (ack),
        .throw    (throw),
        .dy       (dy),
        .dx       (dx),
        .ball_cnt (ball_cnt),
        .over_done(over_done),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int dy;
        int dx;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [18:0] mrand;
    int          mcnt;
    logic        throw_prev = 1'b0;
    int          held_dy;
    int          held_dx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] lfsr_next(input logic [18:0] r);
        int ones;
        ones = 0;
        for (int i = 0; i < 19; i++) begin
            if (TAPS_M[i] && r[i]) ones++;
        end
        return {r[17:0], ((ones % 2) == 1) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_draw();
        int          idx;
        int          v;
        logic [63:0] t;
        exp_t        e;
        idx  = int'(mrand[3:0]);
        t    = DYT >> (4 * idx);
        e.dy = int'(t[3:0]);
        t    = DXT >> (4 * idx);
        v    = int'(t[3:0]) + int'(mode);
        e.dx = (v > 15) ? 15 : v;
        mrand = lfsr_next(mrand);
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin
        if (throw && !throw_prev) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: unexpected throw dy=%0d dx=%0d", dy, dx);
            end else begin
                mon_e = sbq.pop_front();
                check("throw_dy", int'(dy), mon_e.dy);
                check("throw_dx", int'(dx), mon_e.dx);
            end
            held_dy = int'(dy);
            held_dx = int'(dx);
        end else if (throw && throw_prev) begin
            check("hold_dydx", int'({dy, dx}), (held_dy << 4) | held_dx);
        end
        throw_prev = throw;
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        ack   = 1'b0;
        @(posedge clock) #1;
        reset = 1'b0;
        mrand = SEED_M;
        mcnt  = 0;
        sbq.delete();
        check("rst_throw", int'(throw), 0);
        check("rst_dy", int'(dy), 0);
        check("rst_dx", int'(dx), 0);
        check("rst_cnt", int'(ball_cnt), 0);
        check("rst_od", int'(over_done), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    task automatic start_ball();
        int lat;
        bit ok;
        model_draw();
        req = 1'b1;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clock) #1;
            req = 1'b0;
            lat++;
            if (throw) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL throw_timeout: got no throw, expected one");
        end else begin
            check("latency", lat, 3);
        end
    endtask

    task automatic finish_ball(input int hold, input bit gover);
        int expod;
        repeat (hold) @(posedge clock) #1;
        ack      = 1'b1;
        gameOver = gover;
        @(posedge clock) #1;
        ack      = 1'b0;
        gameOver = 1'b0;
        if (mcnt == NBALLS - 1) begin
            mcnt  = 0;
            expod = 1;
        end else begin
            mcnt++;
            expod = 0;
        end
        check("ack_throw", int'(throw), 0);
        check("ack_cnt", int'(ball_cnt), mcnt);
        check("ack_od", int'(over_done), expod);
        if (gover) check("ackgo_busy", int'(busy), 0);
    endtask

    task automatic wait_idle(input bit noise);
        int n;
        n   = 0;
        ack = noise;
        while (busy && n < 20) begin
            @(posedge clock) #1;
            n++;
            if (n == 1) check("od_pulse", int'(over_done), 0);
        end
        ack = 1'b0;
        check("cool_cycles", n, NCOOL);
        check("cool_cnt", int'(ball_cnt), mcnt);
    endtask

    task automatic abort_ball(input bit by_en);
        if (by_en) en = 1'b0;
        else gameOver = 1'b1;
        @(posedge clock) #1;
        en       = 1'b1;
        gameOver = 1'b0;
        check("abort_throw", int'(throw), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_cnt", int'(ball_cnt), mcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        reset    = 1'b1;
        en       = 1'b0;
        gameOver = 1'b0;
        req      = 1'b0;
        mode     = 2'd0;
        ack      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // first two throws from the seed
        en = 1'b1;
        start_ball();
        check("t1_dy", int'(dy), 2);
        check("t1_dx", int'(dx), 4);
        finish_ball(1, 1'b0);
        wait_idle(1'b0);
        start_ball();
        check("t2_dy", int'(dy), 1);
        check("t2_dx", int'(dx), 2);
        finish_ball(0, 1'b0);
        check("t2_cnt", int'(ball_cnt), 2);
        wait_idle(1'b0);

        // difficulty sweep on the first throw
        for (int k = 0; k < 4; k++) begin
            do_reset();
            mode = 2'(k);
            start_ball();
            check("t3_dx", int'(dx), 4 + k);
            finish_ball(0, 1'b0);
            wait_idle(1'b0);
        end

        // a full over
        do_reset();
        mode = 2'd0;
        for (int b = 0; b < NBALLS; b++) begin
            start_ball();
            finish_ball(b % 3, 1'b0);
            wait_idle(1'b1);
        end

        // aborts
        start_ball();
        abort_ball(1'b0);
        start_ball();
        finish_ball(1, 1'b1);

        // reset in PRESENT, in COOL, on the over_done cycle
        start_ball();
        do_reset();
        start_ball();
        finish_ball(0, 1'b0);
        do_reset();
        for (int b = 0; b < NBALLS - 1; b++) begin
            start_ball();
            finish_ball(0, 1'b0);
            wait_idle(1'b0);
        end
        start_ball();
        finish_ball(0, 1'b0);
        check("t6_od", int'(over_done), 1);
        do_reset();
        mode = 2'd0;
        start_ball();
        check("t6_dy", int'(dy), 2);
        check("t6_dx", int'(dx), 4);
        finish_ball(0, 1'b0);
        wait_idle(1'b0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            mode = 2'($urandom_range(0, 3));
            start_ball();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                abort_ball(1'b0);
            end else if (r == 1) begin
                abort_ball(1'b1);
            end else if (r == 2) begin
                finish_ball($urandom_range(0, 3), 1'b1);
            end else begin
                finish_ball($urandom_range(0, 3), 1'b0);
                wait_idle(1'($urandom_range(0, 1)));
            end
        end

        repeat (4) @(posedge clock);
        #1;
        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
